// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative HI/LO multiply-divide unit:
// op codes, FSM state encoding and op-class helper functions.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd1;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd3;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd4;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd5;
  localparam logic [MDU_OP_W-1:0] OP_MADD  = 4'd6;
  localparam logic [MDU_OP_W-1:0] OP_MADDU = 4'd7;
  localparam logic [MDU_OP_W-1:0] OP_MSUB  = 4'd8;
  localparam logic [MDU_OP_W-1:0] OP_MSUBU = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DSET,
    S_DITER,
    S_DFIX
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_mul(input logic [MDU_OP_W-1:0] op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath, one quotient bit per step.
//  clk, reset : clock, synchronous active-high reset
//  load       : take |a| and |b| (magnitudes when sgn=1), clear the remainder
//  step       : perform one restoring iteration
//  sgn        : treat a/b as two's complement when loading
//  a, b       : dividend, divisor
//  quo, rem   : unsigned quotient / remainder magnitudes after WIDTH steps
// Sign fixup and divide-by-zero handling live in the parent.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // quo doubles as the dividend shift register: its MSB feeds the remainder
  // while the new quotient bit enters at the LSB.
  assign rem_sh = {rem, quo[WIDTH-1]};
  // rem < dvsr keeps rem_sh below 2^(WIDTH+1), so bit WIDTH is the sign.
  assign diff   = rem_sh - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= (sgn && a[WIDTH-1]) ? -a : a;
      dvsr <= (sgn && b[WIDTH-1]) ? -b : b;
      rem  <= '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// HI/LO multiply-divide unit with fixed-latency multiply/accumulate and an
// iterative restoring divider.
//  clk, reset     : clock, synchronous active-high reset
//  start, op      : launch op (ignored while busy or when cancel is high)
//  rs, rt         : operand A (dividend / MTHI/MTLO source), operand B (divisor)
//  cancel         : abort the in-flight op, hi/lo untouched
//  busy           : op in flight
//  done, div_zero : completion pulse; div_zero flags a zero divisor
//  hi, lo         : architectural HI/LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    rs,
  input  logic [WIDTH-1:0]    rt,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic                div_zero,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [MDU_OP_W-1:0] op_q;

  logic accept, mul_fin, div_fin;

  assign busy    = (state_q != S_IDLE);
  assign accept  = start && !busy && !cancel;
  assign mul_fin = (state_q == S_MUL) && !cancel && (cnt == CNT_W'(MUL_LAT - 1));
  assign div_fin = (state_q == S_DFIX) && !cancel;

  // ---------------- multiplier / accumulator ----------------
  logic                 msgn;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc, mul_res;

  assign msgn  = is_signed_mul(op_q);
  assign a_ext = {{WIDTH{msgn & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{msgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;   // low 2*WIDTH bits are the exact product mod 2^(2W)
  assign acc   = {hi, lo};

  always_comb begin
    mul_res = prod;
    if (op_q inside {OP_MADD, OP_MADDU})      mul_res = acc + prod;
    else if (op_q inside {OP_MSUB, OP_MSUBU}) mul_res = acc - prod;
  end

  // ---------------- divider ----------------
  logic             sdiv, a_neg, q_neg, dzero;
  logic [WIDTH-1:0] quo, rem, div_lo, div_hi;

  assign sdiv  = (op_q == OP_DIV);
  assign a_neg = sdiv & a_q[WIDTH-1];
  assign q_neg = a_neg ^ (sdiv & b_q[WIDTH-1]);
  assign dzero = (b_q == '0);

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == S_DSET),
    .step  (state_q == S_DITER),
    .sgn   (sdiv),
    .a     (a_q),
    .b     (b_q),
    .quo   (quo),
    .rem   (rem)
  );

  // MIN / -1 needs no special case: |MIN| = 2^(W-1), negated back to MIN.
  always_comb begin
    div_lo = q_neg ? -quo : quo;
    div_hi = a_neg ? -rem : rem;
    if (dzero) begin
      div_lo = '1;
      div_hi = a_q;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op(op))      state_d = S_MUL;
          else if (is_div_op(op)) state_d = S_DSET;
        end
      end
      S_MUL:   if (cancel || cnt == CNT_W'(MUL_LAT - 1)) state_d = S_IDLE;
      S_DSET:  state_d = cancel ? S_IDLE : S_DITER;
      S_DITER: begin
        if (cancel)                         state_d = S_IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))  state_d = S_DFIX;
      end
      S_DFIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      done     <= 1'b0;
      div_zero <= 1'b0;
      // counts edges spent in the current state; restarts on every transition
      cnt      <= (busy && state_d == state_q) ? cnt + 1'b1 : '0;

      if (accept) begin
        a_q  <= rs;
        b_q  <= rt;
        op_q <= op;
        if (op == OP_MTHI) hi <= rs;
        if (op == OP_MTLO) lo <= rs;
      end

      if (mul_fin) begin
        {hi, lo} <= mul_res;
        done     <= 1'b1;
      end

      if (div_fin) begin
        hi       <= div_hi;
        lo       <= div_lo;
        done     <= 1'b1;
        div_zero <= dzero;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LAT=5): a cycle-level reference
// model computed with plain 64-bit arithmetic, checked every cycle, plus
// literal expectations for the documented corner cases.
module tb_mdu_iter;
  localparam int W  = 32;
  localparam int ML = 5;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [3:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] h,
                                             input logic [W-1:0] l);
    longint      sa  = longint'($signed(a));
    longint      sb  = longint'($signed(b));
    logic [63:0] ua  = {32'b0, a};
    logic [63:0] ub  = {32'b0, b};
    logic [63:0] acc = {h, l};
    longint      q, r;
    logic [63:0] uq, ur;
    case (o)
      4'd0: return sa * sb;
      4'd1: return ua * ub;
      4'd6: return acc + sa * sb;
      4'd7: return acc + ua * ub;
      4'd8: return acc - sa * sb;
      4'd9: return acc - ua * ub;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  logic [W-1:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]   m_op;
  bit           m_busy, m_done, m_dz;
  int           m_left;

  always @(posedge clk) begin
    logic [63:0] res;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_busy) begin
        if (cancel) m_busy = 0;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            res          = ref_result(m_op, m_a, m_b, m_hi, m_lo);
            {m_hi, m_lo} = res;
            m_busy       = 0;
            m_done       = 1;
            m_dz         = (m_op == 4'd2 || m_op == 4'd3) && (m_b == 0);
          end
        end
      end else if (start && !cancel) begin
        m_op = op; m_a = rs; m_b = rt;
        case (op)
          4'd4: m_hi = rs;
          4'd5: m_lo = rs;
          4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9: begin m_busy = 1; m_left = ML; end
          4'd2, 4'd3: begin m_busy = 1; m_left = W + 2; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // returns at the negedge where done is high; nb = busy cycles seen before it
  task automatic wait_done(input int bound, output int nb, output logic dz);
    int n = 0;
    nb = 0;
    dz = 1'b0;
    while (n < bound) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      n++;
    end
    if (done !== 1'b1) chk("timeout_done", {63'b0, done}, 64'd1);
    dz = div_zero;
  endtask

  initial begin
    int   nb, ndone;
    logic dz;
    reset = 1; start = 0; cancel = 0; op = 0; rs = 0; rt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);

    // MULT -3 * 7
    issue(4'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(50, nb, dz);
    chk("mult_lat", nb, 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    @(negedge clk);
    chk("mult_done_once", done, 0);

    // MULTU FFFFFFFF * 2
    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    wait_done(50, nb, dz);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // MADD on hi=0 lo=10 with 4*5; started in the done cycle
    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd10, 32'd0);
    issue(4'd6, 32'd4, 32'd5);
    wait_done(50, nb, dz);
    chk("madd_hi", hi, 0);
    chk("madd_lo", lo, 32'd30);

    // MSUBU on 0 with 1*1
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd9, 32'd1, 32'd1);
    wait_done(50, nb, dz);
    chk("msubu_hi", hi, 32'hFFFFFFFF);
    chk("msubu_lo", lo, 32'hFFFFFFFF);

    // MSUB -1 - 2*3 = -7
    issue(4'd8, 32'd2, 32'd3);
    wait_done(50, nb, dz);
    chk("msub_lo", lo, 32'hFFFFFFF9);

    // MADDU -7 + 2^32
    issue(4'd7, 32'h10000, 32'h10000);
    wait_done(50, nb, dz);
    chk("maddu_hi", hi, 0);
    chk("maddu_lo", lo, 32'hFFFFFFF9);

    // DIV -7 / 2
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(80, nb, dz);
    chk("div_lat", nb, 34);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // DIVU 7 / 0
    issue(4'd3, 32'd7, 32'd0);
    wait_done(80, nb, dz);
    chk("divz_flag", dz, 1);
    chk("divz_lat", nb, 34);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'd7);

    // DIV MIN / -1
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(80, nb, dz);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 0);
    chk("divmin_flag", dz, 0);

    // DIVU 100 / 7
    issue(4'd3, 32'd100, 32'd7);
    wait_done(80, nb, dz);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // DIV 7 / -2
    issue(4'd2, 32'd7, 32'hFFFFFFFE);
    wait_done(80, nb, dz);
    chk("div_pn_lo", lo, 32'hFFFFFFFD);
    chk("div_pn_hi", hi, 32'd1);

    // DIV -8 / -3
    issue(4'd2, 32'hFFFFFFF8, 32'hFFFFFFFD);
    wait_done(80, nb, dz);
    chk("div_nn_lo", lo, 32'd2);
    chk("div_nn_hi", hi, 32'hFFFFFFFE);

    // cancel a DIV at cycle 10
    @(negedge clk);
    issue(4'd2, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", busy, 0);
    chk("cancel_hi", hi, 32'hFFFFFFFE);
    chk("cancel_lo", lo, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("cancel_no_done", ndone, 0);

    // MTLO while a MULT is busy is ignored
    issue(4'd0, 32'd2, 32'd3);
    issue(4'd5, 32'hDEAD, 32'd0);
    wait_done(50, nb, dz);
    chk("mtlo_busy_lo", lo, 32'd6);
    chk("mtlo_busy_hi", hi, 0);

    // start together with cancel in IDLE is suppressed
    start = 1'b1; op = 4'd4; rs = 32'h1234; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_start_hi", hi, 0);
    chk("cancel_start_busy", busy, 0);

    // undefined op code
    issue(4'd12, 32'd5, 32'd5);
    @(negedge clk);
    chk("undef_busy", busy, 0);
    chk("undef_lo", lo, 32'd6);

    // cancel on the MULT completion edge wins
    issue(4'd0, 32'd7, 32'd7);
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_fin_busy", busy, 0);
    chk("cancel_fin_done", done, 0);
    chk("cancel_fin_lo", lo, 32'd6);

    // reset in the middle of a DIV
    issue(4'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    repeat (40) @(negedge clk);
    chk("rstmid_quiet", {done, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
